ram_fill_verify: RTL and testbench

Parametrised RAM initialiser and self-checker. It owns a W x L word memory and fills it from a selectable pattern generator on a start pulse. It then reads every word back and compares it with the expected pattern, and reports pass, error count and first failing address. When idle, the memory is exposed to an external read/write port so a checker can inspect it or corrupt it.

---
 rtl/ram_fill_verify_if.sv | 32 +++
 rtl/ram_fill_verify.sv | 138 +++++++++++++
 tb/tb_ram_fill_verify.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fill_verify_if.sv
// Control, status and external memory port bundle for ram_fill_verify.
// The master drives requests and the external port; the slave is the initialiser.
interface ram_fill_verify_if #(
  parameter int W = 32,
  parameter int L = 16
);
  localparam int AW = $clog2(L);

  logic          start;
  logic [1:0]    mode;
  logic          verify_only;
  logic [W-1:0]  seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [W-1:0]  ext_wdata;
  logic [W-1:0]  ext_rdata;

  modport master (
    output start, mode, verify_only, seed, ext_we, ext_addr, ext_wdata,
    input  busy, done, pass, err_count, first_err_addr, ext_rdata
  );

  modport slave (
    input  start, mode, verify_only, seed, ext_we, ext_addr, ext_wdata,
    output busy, done, pass, err_count, first_err_addr, ext_rdata
  );
endinterface

// File: rtl/ram_fill_verify.sv
// RAM initialiser and self-checker: fills a W x L memory from a pattern,
// reads it back, and reports pass / error count / first failing address.
module ram_fill_verify #(
  parameter int W = 32,
  parameter int L = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_fill_verify_if.slave bus
);
  localparam int AW = $clog2(L);
  localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;

  logic [W-1:0]  r_mem [0:L-1];
  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_mode;
  logic [W-1:0]  r_seed;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [AW:0]   r_errCount;
  logic [AW-1:0] r_firstErrAddr;

  logic          w_idleLike;
  logic          w_extInRange;
  logic [W-1:0]  w_expWord;
  logic          w_mismatch;
  logic          w_memWe;
  logic [AW-1:0] w_memAddr;
  logic [W-1:0]  w_memWdata;

  function automatic logic [W-1:0] expWord(input logic [1:0] m,
                                            input logic [W-1:0] s,
                                            input logic [AW-1:0] a);
    logic [W-1:0] aExt;
    aExt = W'(a);
    case (m)
      2'd0:    expWord = s;
      2'd1:    expWord = s + aExt;
      2'd2:    expWord = a[0] ? ~s : s;
      default: expWord = s ^ (W'(1) << (int'(a) % W));
    endcase
  endfunction

  assign w_idleLike   = (r_state == IDLE) || (r_state == DONE);
  assign w_extInRange = ({1'b0, bus.ext_addr} < (AW + 1)'(L));
  assign w_expWord    = expWord(r_mode, r_seed, r_addr);
  assign w_mismatch   = (r_mem[r_addr] != w_expWord);

  // FILL owns the write port; external writes only land when idle and not
  // colliding with a start request, which always takes priority.
  always_comb begin
    w_memWe    = 1'b0;
    w_memAddr  = r_addr;
    w_memWdata = w_expWord;
    if (rst_n) begin
      if (r_state == FILL) begin
        w_memWe = 1'b1;
      end else if (w_idleLike && bus.ext_we && !bus.start && w_extInRange) begin
        w_memWe    = 1'b1;
        w_memAddr  = bus.ext_addr;
        w_memWdata = bus.ext_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memWdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_mode         <= '0;
      r_seed         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_errCount     <= '0;
      r_firstErrAddr <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_mode         <= bus.mode;
            r_seed         <= bus.seed;
            r_addr         <= '0;
            r_errCount     <= '0;
            r_firstErrAddr <= '0;
            r_pass         <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= bus.verify_only ? VERIFY : FILL;
          end
        end
        FILL: begin
          if (r_addr == LAST_ADDR) begin
            r_addr  <= '0;
            r_state <= VERIFY;
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
        VERIFY: begin
          if (w_mismatch) begin
            r_errCount <= r_errCount + (AW + 1)'(1);
            if (r_errCount == '0) begin
              r_firstErrAddr <= r_addr;
            end
          end
          // Pass must account for a mismatch found on this final word.
          if (r_addr == LAST_ADDR) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_errCount == '0) && !w_mismatch;
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_errCount;
  assign bus.first_err_addr = r_firstErrAddr;
  assign bus.ext_rdata      = (!r_busy && w_extInRange) ? r_mem[bus.ext_addr] : '0;
endmodule

// File: tb/tb_ram_fill_verify.sv
// Randomised scoreboard bench for ram_fill_verify: a reference memory model
// predicts each run's outcome, and a monitor checks it when done rises.
module tb_ram_fill_verify;
  localparam int W  = 32;
  localparam int L  = 16;
  localparam int AW = $clog2(L);

  typedef struct {
    bit    expPass;
    int    expErr;
    int    expFirst;
    int    doneCycle;
  } result_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   total = 0;
  int   bad = 0;
  logic prevDone = 1'b0;
  logic [W-1:0] refMem [0:L-1];
  result_t sbQ[$];

  ram_fill_verify_if #(.W(W), .L(L)) bus ();

  ram_fill_verify #(.W(W), .L(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  // Pattern rules written directly from the word definitions.
  function automatic logic [W-1:0] patternWord(input int m, input logic [W-1:0] s, input int a);
    logic [W-1:0] one;
    one = 1;
    case (m)
      0:       return s;
      1:       return s + W'(a);
      2:       return (a % 2 == 1) ? ~s : s;
      default: return s ^ (one << (a % W));
    endcase
  endfunction

  // Monitor: every rising done pops one predicted result.
  always @(negedge clk) begin
    result_t r;
    if (rst_n && bus.done && !prevDone) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        r = sbQ.pop_front();
        checkOutput("done_latency", 64'(cycle), 64'(r.doneCycle));
        checkOutput("pass", 64'(bus.pass), 64'(r.expPass));
        checkOutput("err_count", 64'(bus.err_count), 64'(r.expErr));
        checkOutput("first_err_addr", 64'(bus.first_err_addr), 64'(r.expFirst));
      end
    end
    prevDone <= bus.done;
  end

  task automatic extWrite(input int addr, input logic [W-1:0] data);
    @(negedge clk);
    bus.ext_we    = 1'b1;
    bus.ext_addr  = AW'(addr);
    bus.ext_wdata = data;
    @(posedge clk);
    #1;
    bus.ext_we = 1'b0;
    refMem[addr] = data;
  endtask

  task automatic extReadCheck(input string name, input int addr, input logic [W-1:0] expv);
    @(negedge clk);
    bus.ext_addr = AW'(addr);
    #1;
    checkOutput(name, 64'(bus.ext_rdata), 64'(expv));
  endtask

  task automatic sweepMemory();
    for (int a = 0; a < L; a++) extReadCheck("mem_sweep", a, refMem[a]);
  endtask

  // Issues one start, predicts the result into the scoreboard, then waits for done.
  task automatic applyStimulus(input int m, input logic [W-1:0] s, input bit vo,
                               input bit extDuring, input bit secondStart);
    int eCycle;
    int errs;
    int first;
    bit seenDone;
    result_t r;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.mode        = 2'(m);
    bus.seed        = s;
    bus.verify_only = vo;
    if (extDuring) begin
      bus.ext_we    = 1'b1;
      bus.ext_addr  = AW'(2);
      bus.ext_wdata = '0;
    end
    @(posedge clk);
    #1;
    eCycle    = cycle;
    bus.start = 1'b0;
    if (!vo) for (int a = 0; a < L; a++) refMem[a] = patternWord(m, s, a);
    errs  = 0;
    first = 0;
    for (int a = 0; a < L; a++) begin
      if (refMem[a] !== patternWord(m, s, a)) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
    r.expPass   = (errs == 0);
    r.expErr    = errs;
    r.expFirst  = first;
    r.doneCycle = eCycle + (vo ? L : 2 * L);
    sbQ.push_back(r);
    seenDone = 1'b0;
    for (int n = 0; n < 3 * L; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seenDone = 1'b1;
        break;
      end
      checkOutput("busy_during_run", 64'(bus.busy), 64'd1);
      checkOutput("rdata_zero_busy", 64'(bus.ext_rdata), 64'd0);
      if (secondStart && n == 3) begin
        bus.start = 1'b1;
        bus.mode  = 2'($urandom_range(3));
        bus.seed  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.ext_we = 1'b0;
    bus.start  = 1'b0;
    if (!seenDone) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
      void'(sbQ.pop_back());
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.mode        = '0;
    bus.verify_only = 1'b0;
    bus.seed        = '0;
    bus.ext_we      = 1'b0;
    bus.ext_addr    = '0;
    bus.ext_wdata   = '0;
    for (int a = 0; a < L; a++) refMem[a] = 'x;

    #23;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_pass", 64'(bus.pass), 64'd0);
    checkOutput("rst_err_count", 64'(bus.err_count), 64'd0);
    checkOutput("rst_first_err", 64'(bus.first_err_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] mode 1 fill");
    applyStimulus(1, 32'h10b02823, 1'b0, 1'b0, 1'b0);
    extReadCheck("mode1_addr5", 5, 32'h10b02828);
    extReadCheck("mode1_addr15", 15, 32'h10b02832);
    sweepMemory();

    $display("[TB] mode 2 fill");
    applyStimulus(2, 32'haaaaaaaa, 1'b0, 1'b0, 1'b0);
    extReadCheck("mode2_addr0", 0, 32'haaaaaaaa);
    extReadCheck("mode2_addr1", 1, 32'h55555555);
    extReadCheck("mode2_addr14", 14, 32'haaaaaaaa);

    $display("[TB] corrupt and verify only");
    applyStimulus(0, 32'haaaaaaaa, 1'b0, 1'b0, 1'b0);
    extWrite(3, 32'h0);
    extWrite(9, 32'h12345678);
    applyStimulus(0, 32'haaaaaaaa, 1'b1, 1'b0, 1'b0);
    extReadCheck("mem9_kept", 9, 32'h12345678);
    sweepMemory();

    $display("[TB] reset during verify");
    @(negedge clk);
    bus.start       = 1'b1;
    bus.mode        = 2'd0;
    bus.seed        = 32'haaaaaaaa;
    bus.verify_only = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("mid_verify_err", 64'(bus.err_count), 64'd1);
    checkOutput("mid_verify_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("async_rst_done", 64'(bus.done), 64'd0);
    checkOutput("async_rst_err", 64'(bus.err_count), 64'd0);
    checkOutput("async_rst_first", 64'(bus.first_err_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, $urandom, 1'b0, 1'b0, 1'b0);

    $display("[TB] mode 3 with ignored second start");
    applyStimulus(3, 32'h0, 1'b0, 1'b0, 1'b1);
    extReadCheck("mode3_addr0", 0, 32'h00000001);
    extReadCheck("mode3_addr7", 7, 32'h00000080);
    extReadCheck("mode3_addr15", 15, 32'h00008000);

    $display("[TB] external write during fill");
    applyStimulus(1, 32'h00c0ffee, 1'b0, 1'b1, 1'b0);
    extReadCheck("busy_write_dropped", 2, 32'h00c0fff0);

    $display("[TB] random runs");
    for (int k = 0; k < 6; k++) begin
      int m;
      logic [W-1:0] s;
      bit vo;
      m  = $urandom_range(3);
      s  = $urandom;
      vo = ($urandom_range(1) == 1);
      if ($urandom_range(1) == 1) extWrite($urandom_range(L - 1), $urandom);
      if ($urandom_range(1) == 1) extWrite($urandom_range(L - 1), patternWord(m, s, 4));
      applyStimulus(m, s, vo, 1'b0, 1'b0);
      sweepMemory();
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
